// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control bundle: IF/ID + ID/EX observation in, stall/flush controls out.
// The pipeline side holds the master modport; the controller holds the slave modport.
interface hazard_ctrl_if;
    logic        i_ifid_valid;
    logic [4:0]  i_ifid_rs;
    logic [4:0]  i_ifid_rt;
    logic [2:0]  i_idex_mem_control;
    logic [4:0]  i_idex_tar_reg;
    logic        i_ex_branch_taken;
    logic        o_pc_write;
    logic        o_if_id_write;
    logic        o_if_id_flush;
    logic        o_id_ex_flush;
    logic [1:0]  o_state;
    logic [15:0] o_stall_cnt;
    logic [15:0] o_flush_cnt;

    modport master (
        output i_ifid_valid, i_ifid_rs, i_ifid_rt, i_idex_mem_control,
               i_idex_tar_reg, i_ex_branch_taken,
        input  o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_flush,
               o_state, o_stall_cnt, o_flush_cnt
    );

    modport slave (
        input  i_ifid_valid, i_ifid_rs, i_ifid_rt, i_idex_mem_control,
               i_idex_tar_reg, i_ex_branch_taken,
        output o_pc_write, o_if_id_write, o_if_id_flush, o_id_ex_flush,
               o_state, o_stall_cnt, o_flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use stall / taken-branch flush sequencer; optional statistics under HAZARD_STAT_EN.
// Latency: controls are combinational from state and inputs (0 cycles).
// Backpressure: holds PC and IF/ID upstream while inserting ID/EX bubbles.
module hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_DEPTH       = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    hazard_ctrl_if.slave hz
);
    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_STALL = 2'b01;
    localparam logic [1:0] ST_FLUSH = 2'b10;

    localparam logic [3:0] STALL_LOAD  = 4'(LOAD_STALL_CYCLES - 1);
    localparam logic [3:0] FLUSH_LOAD  = 4'(FLUSH_DEPTH - 1);
    localparam logic [1:0] ST_AFTER_LU = (LOAD_STALL_CYCLES > 1) ? ST_STALL : ST_RUN;
    localparam logic [1:0] ST_AFTER_BR = (FLUSH_DEPTH > 1) ? ST_FLUSH : ST_RUN;

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       load_use;
    logic       pc_write, if_id_write, if_id_flush, id_ex_flush;

    assign load_use = hz.i_idex_mem_control[1] & hz.i_ifid_valid &
                      (hz.i_idex_tar_reg != 5'd0) &
                      ((hz.i_idex_tar_reg == hz.i_ifid_rs) |
                       (hz.i_idex_tar_reg == hz.i_ifid_rt));

    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (hz.i_ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    state_d     = ST_AFTER_BR;
                    cnt_d       = FLUSH_LOAD;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    state_d     = ST_AFTER_LU;
                    cnt_d       = STALL_LOAD;
                end
            end
            ST_STALL: begin
                // A branch resolving in EX kills the stalled instruction anyway.
                if (hz.i_ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    state_d     = ST_AFTER_BR;
                    cnt_d       = FLUSH_LOAD;
                end else begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d   = cnt_q - 4'd1;
                    end
                end
            end
            ST_FLUSH: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (hz.i_ex_branch_taken) begin
                    state_d = ST_AFTER_BR;
                    cnt_d   = FLUSH_LOAD;
                end else if (cnt_q <= 4'd1) begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 4'd0;
            end
        endcase
        if (!i_rst_n) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = 1'b0;
            id_ex_flush = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz.o_pc_write    = pc_write;
    assign hz.o_if_id_write = if_id_write;
    assign hz.o_if_id_flush = if_id_flush;
    assign hz.o_id_ex_flush = id_ex_flush;
    assign hz.o_state       = i_rst_n ? state_q : ST_RUN;

`ifdef HAZARD_STAT_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;
    logic        flush_evt;

    // Every legal state honours a taken branch; the illegal state does not flush.
    assign flush_evt = i_rst_n & hz.i_ex_branch_taken & (state_q != 2'b11);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (!pc_write && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (flush_evt && (flush_cnt_q != 16'hFFFF))
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign hz.o_stall_cnt = stall_cnt_q;
    assign hz.o_flush_cnt = flush_cnt_q;
`else
    assign hz.o_stall_cnt = 16'd0;
    assign hz.o_flush_cnt = 16'd0;
`endif
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline hazard controller that reads the ID/EX stage contents and the IF/ID operand fields.
- Drives the stall and flush controls for the PC, the IF/ID register and the ID/EX register.
- Detects load-use hazards and taken branches resolved in EX.
- Sequences multi-cycle stalls and flush bubbles with a small state machine, so the ID/EX register only ever captures valid instructions or zero-control bubbles.

## Interface
Parameters:
- LOAD_STALL_CYCLES, 1: bubble cycles inserted per load-use hazard (1..15).
- FLUSH_DEPTH, 1: bubble cycles inserted after a taken branch (1..15).

Ports:
- i_clk  input  1  rising-edge clock.
- i_rst_n  input  1  reset; one clock, reset is synchronous and active-low.
- i_ifid_valid  input  1  IF/ID holds a real instruction.
- i_ifid_rs  input  5  source register 1 of the instruction in ID.
- i_ifid_rt  input  5  source register 2 of the instruction in ID.
- i_idex_mem_control  input  3  MEM control currently held in ID/EX: [2] branch, [1] mem_read, [0] mem_write.
- i_idex_tar_reg  input  5  target register currently held in ID/EX.
- i_ex_branch_taken  input  1  branch in EX resolved taken this cycle.
- o_pc_write  output  1  PC update enable.
- o_if_id_write  output  1  IF/ID load enable.
- o_if_id_flush  output  1  load a NOP into IF/ID.
- o_id_ex_flush  output  1  force WB/MEM/EX control inputs of ID/EX to zero (bubble).
- o_state  output  2  FSM state: 00 RUN, 01 STALL, 10 FLUSH.
- o_stall_cnt  output  16  stall-cycle statistic; zero unless HAZARD_STAT_EN is defined.
- o_flush_cnt  output  16  taken-branch flush statistic; zero unless HAZARD_STAT_EN is defined.

## Operation
- load_use = i_idex_mem_control[1] & i_ifid_valid & (i_idex_tar_reg != 0) & (i_idex_tar_reg == i_ifid_rs | i_idex_tar_reg == i_ifid_rt).
- Outputs are combinational from state and inputs (Mealy), so a hazard acts in the same cycle it appears.
- Defaults: o_pc_write=1, o_if_id_write=1, both flushes 0.
- Internal down-counter is 4 bits wide.

RUN:
- i_ex_branch_taken (highest priority):
  - o_if_id_flush=1 and o_id_ex_flush=1; o_pc_write=1 so the branch target loads.
  - If FLUSH_DEPTH>1, go to FLUSH with cnt=FLUSH_DEPTH-1; otherwise stay in RUN.
- else load_use:
  - o_pc_write=0, o_if_id_write=0, o_id_ex_flush=1.
  - If LOAD_STALL_CYCLES>1, go to STALL with cnt=LOAD_STALL_CYCLES-1; otherwise stay in RUN.

STALL:
- Outputs: o_pc_write=0, o_if_id_write=0, o_id_ex_flush=1.
- cnt decrements each cycle; at cnt==1, return to RUN at the next edge.
- i_ex_branch_taken in STALL overrides: behave as the RUN branch case, with the new FSM state taken from FLUSH_DEPTH.

FLUSH:
- Outputs: o_if_id_flush=1, o_id_ex_flush=1, o_pc_write=1.
- cnt decrements; at cnt==1, return to RUN.
- load_use is ignored in FLUSH because the IF/ID contents are wrong-path.
- A new i_ex_branch_taken in FLUSH reloads cnt=FLUSH_DEPTH-1.

Illegal state 11: return to RUN next edge; outputs take default values.

## Timing
- Reset (i_rst_n=0 sampled at a rising edge): state=RUN, cnt=0, o_stall_cnt=0, o_flush_cnt=0.
- While i_rst_n=0, outputs are forced to o_pc_write=1, o_if_id_write=1, o_if_id_flush=0, o_id_ex_flush=0, o_state=00, regardless of other inputs.
- Reset asserted mid-STALL or mid-FLUSH aborts the sequence; RUN resumes in the first cycle after release.
- Hazard-to-control latency is 0 cycles (same cycle).
- A load-use hazard with LOAD_STALL_CYCLES=N holds the PC for exactly N cycles.
- A taken branch with FLUSH_DEPTH=M produces exactly M cycles of o_id_ex_flush.

## Configuration
HAZARD_STAT_EN:
- Defined:
  - o_stall_cnt increments on every non-reset cycle with o_pc_write=0.
  - o_flush_cnt increments on every cycle where i_ex_branch_taken causes a flush.
  - Both counters saturate at 16'hFFFF and clear on reset.
- Undefined: counter registers are not built; both ports are tied to 16'd0.

## Test plan
- Load-use, LOAD_STALL_CYCLES=1: i_idex_mem_control=3'b010, i_idex_tar_reg=5, i_ifid_rs=5, i_ifid_valid=1 -> one cycle with o_pc_write=0, o_if_id_write=0, o_id_ex_flush=1; state stays 00.
- Load-use, LOAD_STALL_CYCLES=3, hazard pulsed for 1 cycle -> o_pc_write=0 for exactly 3 cycles; o_state sequence 00,01,01,00; o_stall_cnt=3 with HAZARD_STAT_EN.
- tar_reg=0 matching rs=0, or i_ifid_valid=0 -> no stall; all outputs at defaults.
- FLUSH_DEPTH=2, i_ex_branch_taken=1 together with an active load_use -> branch wins: two cycles of o_if_id_flush=o_id_ex_flush=1, o_pc_write=1, no stall; o_flush_cnt=1.
- i_rst_n=0 asserted during the second STALL cycle -> outputs at reset values immediately; o_state=00 after release; counters cleared.
- Saturation with HAZARD_STAT_EN: o_stall_cnt preloaded or driven to 16'hFFFF, further stall cycles -> holds 16'hFFFF.
